vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream raster source for every flag renderer: produces pix_x/pix_y, sync and blanking for 640x480@60 Hz at the 25.175 MHz pixel clock.
- Flag modules decode colour from pix_x/pix_y. This block also supplies frame-rate events and a frame counter for animated or dithered flags.
- The downstream output stage masks colour with display_on.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  clock enable; counters and frame_cnt hold when low
- pix_x  out  10  horizontal counter, 0..H_TOTAL-1 (800)
- pix_y  out  10  vertical counter, 0..V_TOTAL-1 (525)
- hsync  out  1  horizontal sync at SYNC_POL level
- vsync  out  1  vertical sync at SYNC_POL level
- display_on  out  1  high when pix_x<H_ACTIVE and pix_y<V_ACTIVE
- line_start  out  1  high while pix_x==0
- frame_start  out  1  high while pix_x==0 and pix_y==0
- frame_cnt  out  8  completed-frame counter

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset). Resetting drives h and v to 0 and frame_cnt to 0 immediately, mid-line or mid-frame.
- Counters:
  - h and v are registered. pix_x = h, pix_y = v.
  - H_TOTAL = sum of the H_* parameters; V_TOTAL likewise.
  - On each clk edge with ena=1: if h==H_TOTAL-1, h<=0; otherwise h<=h+1.
  - v advances only when h wraps. If v==V_TOTAL-1, v<=0; otherwise v<=v+1.
- frame_cnt: increments modulo 256 on the edge where (h,v) goes from (799,524) to (0,0). 255 wraps to 0.
- ena=0: all state holds and outputs stay stable. A wrap condition with ena=0 does not advance anything.
- Decode (combinational from h and v, without the optional feature):
  - hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vsync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
  - Inactive level = ~SYNC_POL.
- Values during reset: pix_x=0, pix_y=0, display_on=1, line_start=1, frame_start=1, hsync/vsync inactive, frame_cnt=0.
- Widths: all comparisons use 10 bits. H_TOTAL and V_TOTAL must be at most 1024.
- Latency: zero cycles between counters and decoded outputs.

Optional Feature:
- Macro: VGA_SYNC_PIPE_EN.
- When defined: hsync, vsync and display_on come from one register stage (ena-gated). They lag pix_x/pix_y by exactly one clk, aligning with a downstream registered colour stage. Reset values: hsync/vsync inactive, display_on=0.
- pix_x, pix_y, line_start, frame_start and frame_cnt are unaffected.
- When undefined: purely combinational decode as above.

Decomposition:
- Package vga_timing_pkg holds:
  - default H_*/V_* constants
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - the 10-bit coordinate typedef
- Sub-module vga_axis_counter: parameterised wrap counter with terminal-count output and sync-window decode. It is instantiated for h (enable = ena) and for v (enable = ena & h terminal count).

Test Plan:
1. Release reset, ena=1, run 800 clks -> pix_x steps 0..799 then returns to 0; pix_y steps 0->1 on that edge; line_start high exactly at pix_x=0.
2. Sample hsync across one line (SYNC_POL=0) -> low for exactly 96 clks, first at pix_x=656, last at 751; display_on low from pix_x=640.
3. Run 420000 clks (one frame) -> vsync low exactly for pix_y 490..491; frame_start pulses once; frame_cnt 0->1 at (0,0).
4. Force frame_cnt to 255 via 256 frames (or bench-accelerated parameters H_TOTAL=8, V_TOTAL=4) -> wraps to 0; no glitch on frame_start.
5. Hold ena=0 for 50 clks at pix_x=799, pix_y=524 -> nothing changes; first ena=1 edge -> (0,0) and frame_cnt+1.
6. Assert reset asynchronously mid-line at pix_x=300, pix_y=200 -> outputs return to reset values before the next clk edge. With VGA_SYNC_PIPE_EN: hsync toggles at pix_x=657 and 753, one clk after the unpipelined edges.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 raster timing generator.
package vga_timing_pkg;
  typedef logic [9:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;
endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle: generator drives coordinates, syncs and frame events; consumer drives ena.
interface vga_timing_if;
  import vga_timing_pkg::*;
  logic       ena;
  coord_t     pix_x;
  coord_t     pix_y;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (input ena, output pix_x, pix_y, hsync, vsync, display_on,
                  line_start, frame_start, frame_cnt);
  modport slave  (output ena, input pix_x, pix_y, hsync, vsync, display_on,
                  line_start, frame_start, frame_cnt);
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping counter with terminal count, active-region and sync-window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = HS_START,
  parameter int SYNC_END   = HS_END
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output coord_t cnt,
  output logic   tc,
  output logic   active,
  output logic   in_sync
);
  localparam coord_t LAST = coord_t'(TOTAL - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 10'd1;
  end

  assign tc      = (cnt == LAST);
  assign active  = (cnt < coord_t'(ACTIVE));
  assign in_sync = (cnt >= coord_t'(SYNC_START)) && (cnt < coord_t'(SYNC_END));
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, syncs, blanking and frame counter.
// Define VGA_SYNC_PIPE_EN to register hsync/vsync/display_on one clk behind pix_x/pix_y.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input logic          clk,
  input logic          reset,
  vga_timing_if.master vga
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS  = H_ACTIVE + H_FP;
  localparam int V_SS  = V_ACTIVE + V_FP;

  coord_t     h, v;
  logic       h_tc, v_tc, h_act, v_act, h_sy, v_sy;
  logic [7:0] frame_cnt;
  logic       hs_c, vs_c, de_c;

  vga_axis_counter #(.TOTAL(H_TOT), .ACTIVE(H_ACTIVE), .SYNC_START(H_SS),
                     .SYNC_END(H_SS + H_SYNC)) u_h (
    .clk(clk), .reset(reset), .en(vga.ena),
    .cnt(h), .tc(h_tc), .active(h_act), .in_sync(h_sy));

  // v steps only on the edge where h wraps
  vga_axis_counter #(.TOTAL(V_TOT), .ACTIVE(V_ACTIVE), .SYNC_START(V_SS),
                     .SYNC_END(V_SS + V_SYNC)) u_v (
    .clk(clk), .reset(reset), .en(vga.ena & h_tc),
    .cnt(v), .tc(v_tc), .active(v_act), .in_sync(v_sy));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       frame_cnt <= '0;
    else if (vga.ena && h_tc && v_tc) frame_cnt <= frame_cnt + 8'd1;
  end

  assign hs_c = h_sy ? SYNC_POL : ~SYNC_POL;
  assign vs_c = v_sy ? SYNC_POL : ~SYNC_POL;
  assign de_c = h_act & v_act;

`ifdef VGA_SYNC_PIPE_EN
  logic hs_q, vs_q, de_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      de_q <= 1'b0;
    end else if (vga.ena) begin
      hs_q <= hs_c;
      vs_q <= vs_c;
      de_q <= de_c;
    end
  end

  assign vga.hsync      = hs_q;
  assign vga.vsync      = vs_q;
  assign vga.display_on = de_q;
`else
  assign vga.hsync      = hs_c;
  assign vga.vsync      = vs_c;
  assign vga.display_on = de_c;
`endif

  assign vga.pix_x       = h;
  assign vga.pix_y       = v;
  assign vga.line_start  = (h == '0);
  assign vga.frame_start = (h == '0) && (v == '0);
  assign vga.frame_cnt   = frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: two generators (full line / short frame, and a tiny raster) checked every cycle
// against an arithmetic model derived from the count of enabled edges since reset.
module tb_vga_timing_gen;
  // DUT A: full 800-pixel line, 12-line frame, active-low syncs
  localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VA = 6,   A_VFP = 2,  A_VS = 2,  A_VBP = 2;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
  // DUT B: 8x4 raster, active-high syncs
  localparam int B_HA = 4, B_HFP = 1, B_HS = 2, B_HBP = 1;
  localparam int B_VA = 2, B_VFP = 1, B_VS = 1, B_VBP = 0;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
`ifdef VGA_SYNC_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] x, y;
    logic hs, vs, de, ls, fs;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, ena_a, ena_b;
  int   errors = 0, checks = 0;
  bit   cmp_on = 1'b0;
  longint n_a, n_b;
  exp_t pq_a, pq_b;

  always #5 clk = ~clk;

  vga_timing_if ia ();
  vga_timing_if ib ();
  assign ia.ena = ena_a;
  assign ib.ena = ena_b;

  vga_timing_gen #(.H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
                   .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
                   .SYNC_POL(1'b0)) dut_a (.clk(clk), .reset(rst_a), .vga(ia));
  vga_timing_gen #(.H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
                   .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
                   .SYNC_POL(1'b1)) dut_b (.clk(clk), .reset(rst_b), .vga(ib));

  // Position after n enabled edges, straight from the raster arithmetic
  function automatic exp_t model(longint n, int ha, int hfp, int hs, int hbp,
                                 int va, int vfp, int vs, int vbp, bit pol);
    exp_t e;
    int ht = ha + hfp + hs + hbp, vt = va + vfp + vs + vbp;
    int x = int'(n % ht), y = int'((n / ht) % vt);
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.fc = 8'((n / (ht * vt)) % 256);
    e.hs = (x >= ha + hfp && x < ha + hfp + hs) ? pol : ~pol;
    e.vs = (y >= va + vfp && y < va + vfp + vs) ? pol : ~pol;
    e.de = (x < ha) && (y < va);
    e.ls = (x == 0);
    e.fs = (x == 0) && (y == 0);
    return e;
  endfunction

  function automatic exp_t mod_a(longint n);
    return model(n, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, 1'b0);
  endfunction
  function automatic exp_t mod_b(longint n);
    return model(n, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1);
  endfunction

  // Reference state: enabled-edge count plus the delayed decode for the pipelined build
  always @(posedge clk or posedge rst_a)
    if (rst_a) begin
      n_a <= 0;
      pq_a <= '{x: 0, y: 0, hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0, fc: 0};
    end else if (ena_a) begin
      pq_a <= mod_a(n_a);
      n_a  <= n_a + 1;
    end

  always @(posedge clk or posedge rst_b)
    if (rst_b) begin
      n_b <= 0;
      pq_b <= '{x: 0, y: 0, hs: 1'b0, vs: 1'b0, de: 1'b0, ls: 1'b0, fs: 1'b0, fc: 0};
    end else if (ena_b) begin
      pq_b <= mod_b(n_b);
      n_b  <= n_b + 1;
    end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp(string tag, exp_t e, exp_t pq, exp_t g);
    if (PIPE) begin
      e.hs = pq.hs;
      e.vs = pq.vs;
      e.de = pq.de;
    end
    chk({tag, ".pix_x"}, 32'(g.x), 32'(e.x));
    chk({tag, ".pix_y"}, 32'(g.y), 32'(e.y));
    chk({tag, ".hsync"}, 32'(g.hs), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(g.vs), 32'(e.vs));
    chk({tag, ".display_on"}, 32'(g.de), 32'(e.de));
    chk({tag, ".line_start"}, 32'(g.ls), 32'(e.ls));
    chk({tag, ".frame_start"}, 32'(g.fs), 32'(e.fs));
    chk({tag, ".frame_cnt"}, 32'(g.fc), 32'(e.fc));
  endtask

  function automatic exp_t got(logic [9:0] x, logic [9:0] y, logic hs, logic vs,
                               logic de, logic ls, logic fs, logic [7:0] fc);
    return '{x: x, y: y, hs: hs, vs: vs, de: de, ls: ls, fs: fs, fc: fc};
  endfunction

  always @(negedge clk) if (cmp_on) begin
    cmp("A", mod_a(n_a), pq_a, got(ia.pix_x, ia.pix_y, ia.hsync, ia.vsync, ia.display_on,
                                   ia.line_start, ia.frame_start, ia.frame_cnt));
    cmp("B", mod_b(n_b), pq_b, got(ib.pix_x, ib.pix_y, ib.hsync, ib.vsync, ib.display_on,
                                   ib.line_start, ib.frame_start, ib.frame_cnt));
  end

  initial begin
    int lo_cnt, lo_first, lo_last, fs_cnt, vs_cnt, fc255;
    rst_a = 1'b1; rst_b = 1'b1; ena_a = 1'b0; ena_b = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.pix_x", 32'(ia.pix_x), 0);
    chk("reset.pix_y", 32'(ia.pix_y), 0);
    chk("reset.display_on", 32'(ia.display_on), PIPE ? 0 : 1);
    chk("reset.line_start", 32'(ia.line_start), 1);
    chk("reset.frame_start", 32'(ia.frame_start), 1);
    chk("reset.hsync", 32'(ia.hsync), 1);
    chk("reset.frame_cnt", 32'(ia.frame_cnt), 0);

    // One full line: hsync window and blanking start
    @(posedge clk); #2;
    rst_a = 1'b0; rst_b = 1'b0; ena_a = 1'b1; ena_b = 1'b1;
    lo_cnt = 0; lo_first = -1; lo_last = -1;
    for (int i = 0; i < A_HT; i++) begin
      @(negedge clk);
      if (ia.hsync == 1'b0) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = i;
        lo_last = i;
      end
      if (i == 639 + (PIPE ? 1 : 0)) chk("line.de_last_on", 32'(ia.display_on), 1);
      if (i == 640 + (PIPE ? 1 : 0)) chk("line.de_first_off", 32'(ia.display_on), 0);
    end
    chk("line.hsync_width", lo_cnt, 96);
    chk("line.hsync_first", lo_first, PIPE ? 657 : 656);
    chk("line.hsync_last", lo_last, PIPE ? 752 : 751);
    @(negedge clk);
    chk("line.wrap_x", 32'(ia.pix_x), 0);
    chk("line.wrap_y", 32'(ia.pix_y), 1);

    // Rest of the frame up to and including (0,0) of frame 1
    fs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < A_HT * A_VT - A_HT; i++) begin
      @(negedge clk);
      if (ia.frame_start) fs_cnt++;
      if (ia.vsync == 1'b0) vs_cnt++;
    end
    chk("frame.fs_pulses", fs_cnt, 1);
    chk("frame.vsync_clks", vs_cnt, 2 * A_HT);
    chk("frame.cnt1", 32'(ia.frame_cnt), 1);
    chk("frame.x0", 32'(ia.pix_x), 0);
    chk("frame.y0", 32'(ia.pix_y), 0);

    // Park at the last pixel of the frame with ena low
    repeat (A_HT * A_VT - 1) @(posedge clk);
    #2 ena_a = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold.x", 32'(ia.pix_x), 799);
    chk("hold.y", 32'(ia.pix_y), A_VT - 1);
    chk("hold.fc", 32'(ia.frame_cnt), 1);
    @(posedge clk); #2 ena_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("resume.x", 32'(ia.pix_x), 0);
    chk("resume.y", 32'(ia.pix_y), 0);
    chk("resume.fc", 32'(ia.frame_cnt), 2);

    // Asynchronous reset mid-line at (300,3)
    repeat (3 * A_HT + 300) @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("areset.x", 32'(ia.pix_x), 0);
    chk("areset.y", 32'(ia.pix_y), 0);
    chk("areset.fc", 32'(ia.frame_cnt), 0);
    chk("areset.ls", 32'(ia.line_start), 1);
    chk("areset.fs", 32'(ia.frame_start), 1);
    @(posedge clk); #2 rst_a = 1'b0;

    // frame_cnt wrap on the tiny raster: 256 frames, one frame_start each
    rst_b = 1'b1;
    @(posedge clk); @(posedge clk); #2 rst_b = 1'b0;
    @(negedge clk);
    fs_cnt = 0; fc255 = -1;
    for (int k = 1; k <= 256 * B_HT * B_VT; k++) begin
      @(negedge clk);
      if (ib.frame_start) fs_cnt++;
      if (k == 256 * B_HT * B_VT - 1) fc255 = int'(ib.frame_cnt);
    end
    chk("wrap.fs_pulses", fs_cnt, 256);
    chk("wrap.fc255", fc255, 255);
    chk("wrap.fc0", 32'(ib.frame_cnt), 0);

    // Random enables and occasional resets, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      ena_a = ($urandom_range(0, 3) != 0);
      ena_b = ($urandom_range(0, 3) != 0);
      rst_a = ($urandom_range(0, 499) == 0);
      rst_b = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #2 rst_a = 1'b0; rst_b = 1'b0;
    repeat (4) @(negedge clk);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
